// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router: header decode, payload/parity load,
// full-FIFO stall, busy-destination wait and soft-reset abort.
module router_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       sft_rst_0,
    input  logic       sft_rst_1,
    input  logic       sft_rst_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_en_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    localparam int unsigned ADDR_W = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                sel_empty, sel_sft, hdr_empty;

    // Per-destination status selected by the latched address (port 3 does not exist)
    always_comb begin
        sel_empty = 1'b0;
        sel_sft   = 1'b0;
        case (addr_q)
            2'd0:    begin sel_empty = fifo_empty_0; sel_sft = sft_rst_0; end
            2'd1:    begin sel_empty = fifo_empty_1; sel_sft = sft_rst_1; end
            2'd2:    begin sel_empty = fifo_empty_2; sel_sft = sft_rst_2; end
            default: begin sel_empty = 1'b0;         sel_sft = 1'b0;      end
        endcase
    end

    // Emptiness of the destination named by the header currently on data_in
    always_comb begin
        hdr_empty = 1'b0;
        case (data_in)
            2'd0:    hdr_empty = fifo_empty_0;
            2'd1:    hdr_empty = fifo_empty_1;
            2'd2:    hdr_empty = fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
    end

    // State and address registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        detect_add   = 1'b0;
        lfd_state    = 1'b0;
        ld_state     = 1'b0;
        laf_state    = 1'b0;
        full_state   = 1'b0;
        write_en_reg = 1'b0;
        rst_int_reg  = 1'b0;
        busy         = 1'b1;
        case (state_q)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
                if (pkt_valid) begin
                    addr_d = data_in;
                    if (data_in != 2'd3) begin
                        state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA: begin
                lfd_state    = 1'b1;
                write_en_reg = 1'b1;
                state_d      = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state     = 1'b1;
                write_en_reg = 1'b1;
                busy         = 1'b0;
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                laf_state    = 1'b1;
                write_en_reg = 1'b1;
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: begin
                write_en_reg = 1'b1;
                state_d      = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                state_d     = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) state_d = LOAD_FIRST_DATA;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // Destination timeout abandons the packet regardless of progress
        if (state_q != DECODE_ADDRESS && sel_sft) state_d = DECODE_ADDRESS;
    end

endmodule

// File: tb/tb_router_fsm.sv
// Randomized scoreboard bench for router_fsm against a packet-level reference model.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
    logic       sft_rst_0 = 1'b0, sft_rst_1 = 1'b0, sft_rst_2 = 1'b0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_en_reg, rst_int_reg, busy;

    router_fsm dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .sft_rst_0(sft_rst_0), .sft_rst_1(sft_rst_1),
        .sft_rst_2(sft_rst_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_en_reg(write_en_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Packet phases of the reference model
    typedef enum int {PH_IDLE, PH_HEADER, PH_PAYLOAD, PH_STALL, PH_RESUME,
                      PH_PARITY, PH_CHECK, PH_WAIT} phase_t;

    phase_t     m_phase = PH_IDLE;
    int         m_dest  = 0;
    logic [7:0] exp_q[$];

    // Next-cycle stimulus, applied by step()
    logic       n_rst, n_pv, n_ff, n_pd, n_lpv;
    logic [1:0] n_d;
    logic [2:0] n_empty, n_sft;

    // Expected {detect,lfd,ld,laf,full,we,rst_int,busy} for a phase
    function automatic logic [7:0] phase_outputs(input phase_t p);
        case (p)
            PH_IDLE:    return 8'b1000_0000;
            PH_HEADER:  return 8'b0100_0101;
            PH_PAYLOAD: return 8'b0010_0100;
            PH_STALL:   return 8'b0000_1001;
            PH_RESUME:  return 8'b0001_0101;
            PH_PARITY:  return 8'b0000_0101;
            PH_CHECK:   return 8'b0000_0011;
            default:    return 8'b0000_0001;
        endcase
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled
    task automatic model_clock();
        logic [2:0] empt, sft;
        logic       dest_sft;
        empt = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        sft  = {sft_rst_2, sft_rst_1, sft_rst_0};
        dest_sft = (m_dest < 3) ? sft[m_dest] : 1'b0;
        if (!rst) begin
            m_phase = PH_IDLE;
            m_dest  = 0;
        end else if (m_phase != PH_IDLE && dest_sft) begin
            m_phase = PH_IDLE;
        end else begin
            case (m_phase)
                PH_IDLE: if (pkt_valid) begin
                    m_dest = int'(data_in);
                    if (m_dest < 3) m_phase = empt[m_dest] ? PH_HEADER : PH_WAIT;
                end
                PH_HEADER:  m_phase = PH_PAYLOAD;
                PH_PAYLOAD: m_phase = fifo_full ? PH_STALL : (pkt_valid ? PH_PAYLOAD : PH_PARITY);
                PH_STALL:   m_phase = fifo_full ? PH_STALL : PH_RESUME;
                PH_RESUME:  m_phase = parity_done ? PH_IDLE : (low_pkt_valid ? PH_PARITY : PH_PAYLOAD);
                PH_PARITY:  m_phase = PH_CHECK;
                PH_CHECK:   m_phase = fifo_full ? PH_STALL : PH_IDLE;
                default:    m_phase = (m_dest < 3 && empt[m_dest]) ? PH_HEADER : PH_WAIT;
            endcase
        end
    endtask

    // One cycle: update model on the edge, then apply new inputs mid-cycle
    task automatic step();
        @(posedge clk);
        #1;
        model_clock();
        #2;
        rst = n_rst; pkt_valid = n_pv; data_in = n_d; fifo_full = n_ff;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = n_empty;
        {sft_rst_2, sft_rst_1, sft_rst_0} = n_sft;
        parity_done = n_pd; low_pkt_valid = n_lpv;
        if (!rst) begin
            m_phase = PH_IDLE;
            m_dest  = 0;
        end
        exp_q.push_back(phase_outputs(m_phase));
    endtask

    task automatic set_idle();
        n_rst = 1'b1; n_pv = 1'b0; n_d = 2'd0; n_ff = 1'b0; n_pd = 1'b0; n_lpv = 1'b0;
        n_empty = 3'b111; n_sft = 3'b000;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compares DUT outputs against the queued expectation each cycle
    initial begin
        logic [7:0] act, exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {detect_add, lfd_state, ld_state, laf_state, full_state,
                       write_en_reg, rst_int_reg, busy};
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL outputs t=%0t actual=%b required=%b (detect,lfd,ld,laf,full,we,rst_int,busy)",
                             $time, act, exp);
                end
            end
        end
    end

    initial begin
        set_idle();
        n_rst = 1'b0;
        steps(3);
        // Valid packet to empty port 1
        set_idle(); n_pv = 1'b1; n_d = 2'd1;
        steps(4);
        n_pv = 1'b0;
        steps(4);
        // Invalid address 3 held for 5 cycles
        n_pv = 1'b1; n_d = 2'd3;
        steps(5);
        // Busy port 2: wait, data_in changes ignored, then drain
        set_idle(); n_pv = 1'b1; n_d = 2'd2; n_empty = 3'b011;
        step();
        for (int i = 0; i < 6; i++) begin
            n_d = 2'($urandom_range(0, 3));
            n_empty = {1'b0, 2'($urandom_range(0, 3))};
            step();
        end
        n_empty = 3'b111;
        steps(3);
        n_pv = 1'b0;
        steps(4);
        // Full stall with pkt_valid falling during the stall
        set_idle(); n_pv = 1'b1; n_d = 2'd0;
        steps(3);
        n_ff = 1'b1;
        step();
        n_pv = 1'b0; n_lpv = 1'b1;
        steps(3);
        n_ff = 1'b0;
        steps(5);
        // Wait on port 0; foreign timeout ignored, own timeout aborts
        set_idle(); n_pv = 1'b1; n_d = 2'd0; n_empty = 3'b110;
        step();
        n_pv = 1'b0;
        steps(2);
        n_sft = 3'b010; step();
        n_sft = 3'b000; steps(2);
        n_sft = 3'b001; step();
        n_sft = 3'b000; steps(3);
        // Asynchronous reset in the middle of payload
        set_idle(); n_pv = 1'b1; n_d = 2'd2;
        steps(4);
        n_rst = 1'b0; step();
        n_rst = 1'b1; n_pv = 1'b0; steps(3);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            n_rst   = ($urandom_range(0, 199) != 0);
            n_pv    = ($urandom_range(0, 99) < 80);
            n_d     = 2'($urandom_range(0, 3));
            n_ff    = ($urandom_range(0, 99) < 12);
            n_empty = {($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70),
                       ($urandom_range(0, 99) < 70)};
            n_sft   = {($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 3),
                       ($urandom_range(0, 99) < 3)};
            n_pd    = ($urandom_range(0, 99) < 20);
            n_lpv   = ($urandom_range(0, 99) < 30);
            step();
        end
        set_idle();
        steps(2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
